// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter.
// Grants one access per cycle, combinationally in the request cycle. Loads
// return one cycle later, routed back by a 1-bit tag. Accesses outside
// SIZE words never reach memory; instead they get an error response.
module dmem_arbiter #(
  parameter int SIZE  = 4096,
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_mask,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_mask,
  input  logic        r1_lock,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_sdata,
  output logic        mem_lenable,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_ldata
);

  localparam logic [31:0] SIZE_W = 32'(SIZE);

  // r_last: 1 when requester 1 won the most recent accepted access
  logic        r_last;
  logic        r_g1_prev;
  logic        r_rsp_vld;
  logic        r_rsp_tag;
  logic        r_rsp_err;
  logic [31:0] r_addr_q;
  logic [31:0] r_sdata_q;

  logic [1:0]       w_gnt;
  logic             w_acc;
  logic             w_sel;
  logic             w_we_s;
  logic [31:0]      w_addr_s;
  logic [31:0]      w_wdata_s;
  logic [3:0]       w_mask_s;
  logic             w_in_range;
  logic             w_issue;
  logic [1:0]       w_rvalid;
  logic [1:0]       w_err;
  logic [1:0][31:0] w_rdata;

  // Grant: a held lock wins outright, then round-robin or fixed priority
  // under contention, otherwise the lone requester.
  always_comb begin
    w_gnt = 2'b00;
    if (!rst) begin
      if (r1_req && r1_lock && r_g1_prev)
        w_gnt = 2'b10;
      else if (r0_req && r1_req)
        w_gnt = (RR_EN && !r_last) ? 2'b10 : 2'b01;
      else
        w_gnt = {r1_req, r0_req};
    end
  end

  assign w_acc     = |w_gnt;
  assign w_sel     = w_gnt[1];
  assign w_we_s    = w_sel ? r1_we    : r0_we;
  assign w_addr_s  = w_sel ? r1_addr  : r0_addr;
  assign w_wdata_s = w_sel ? r1_wdata : r0_wdata;
  assign w_mask_s  = w_sel ? r1_mask  : r0_mask;

  // Word index compared against SIZE; byte offset bits are ignored.
  assign w_in_range = ({2'b00, w_addr_s[31:2]} < SIZE_W);
  assign w_issue    = w_acc && w_in_range;

  // Memory strobes are only ever raised for accepted, in-range accesses.
  always_comb begin
    mem_lenable = w_issue && !w_we_s;
    mem_mask    = (w_issue && w_we_s) ? w_mask_s : 4'b0000;
    mem_addr    = rst ? 32'h0 : (w_issue ? w_addr_s : r_addr_q);
    mem_sdata   = rst ? 32'h0 : ((w_issue && w_we_s) ? w_wdata_s : r_sdata_q);
  end

  // Arbitration history, pending response and held memory-bus values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= 1'b1;
      r_g1_prev <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rsp_tag <= 1'b0;
      r_rsp_err <= 1'b0;
      r_addr_q  <= 32'h0;
      r_sdata_q <= 32'h0;
    end else begin
      if (w_acc) r_last <= w_sel;
      r_g1_prev <= w_gnt[1];
      // Loads and any out-of-range access respond; in-range stores do not.
      r_rsp_vld <= w_acc && !(w_in_range && w_we_s);
      r_rsp_tag <= w_sel;
      r_rsp_err <= !w_in_range;
      if (w_issue) r_addr_q <= w_addr_s;
      if (w_issue && w_we_s) r_sdata_q <= w_wdata_s;
    end
  end

  // Per-requester response steering; rdata is forced to zero when not valid.
  for (genvar g = 0; g < 2; g++) begin : g_rsp
    assign w_rvalid[g] = !rst && r_rsp_vld && (r_rsp_tag == 1'(g));
    assign w_err[g]    = w_rvalid[g] && r_rsp_err;
    assign w_rdata[g]  = (w_rvalid[g] && !r_rsp_err) ? mem_ldata : 32'h0;
  end

  assign r0_gnt    = w_gnt[0];
  assign r1_gnt    = w_gnt[1];
  assign r0_rvalid = w_rvalid[0];
  assign r1_rvalid = w_rvalid[1];
  assign r0_err    = w_err[0];
  assign r1_err    = w_err[1];
  assign r0_rdata  = w_rdata[0];
  assign r1_rdata  = w_rdata[1];

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 4096, giving data memory depth in 32-bit words.
REQ-002 SHALL have parameter RR_EN, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with requester 0 winning.
REQ-003 SHALL have port clk, input, 1, single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have, per requester n in {0,1}: rn_req input 1; rn_we input 1 (1=store, 0=load); rn_addr input 32 (byte address); rn_wdata input 32; rn_mask input 4 (store byte enables).
REQ-006 SHALL have, per requester n: rn_gnt output 1; rn_rvalid output 1; rn_rdata output 32; rn_err output 1.
REQ-007 SHALL have r1_lock, input, 1, which holds the grant on requester 1 while asserted.
REQ-008 SHALL have memory-side ports: mem_addr output 32; mem_sdata output 32; mem_lenable output 1; mem_mask output 4; mem_ldata input 32, valid one cycle after mem_lenable.

Function
REQ-009 SHALL issue at most one access per cycle; rn_gnt SHALL be combinational in the same cycle as rn_req and SHALL be one-hot or zero.
REQ-010 SHALL treat a request as accepted only in a cycle where rn_req=1 and rn_gnt=1; the requester holds all request signals stable until that cycle.
REQ-011 With only one requester active, that requester SHALL be granted immediately.
REQ-012 With both active and RR_EN=1, SHALL grant the requester not granted most recently; the last-grant register SHALL update only on an accepted access.
REQ-013 With both active and RR_EN=0, SHALL grant requester 0.
REQ-014 If r1_lock=1 and requester 1 was granted in the previous cycle, SHALL grant requester 1 whenever r1_req=1, overriding REQ-012 and REQ-013; requester 0 stalls.
REQ-015 If r1_lock=1 and r1_req=0, requester 0 SHALL be granted normally.
REQ-016 SHALL implement the address range check as word index = addr[31:2], in range iff the index is less than SIZE.
REQ-017 On an accepted in-range load, SHALL drive mem_addr=rn_addr, mem_lenable=1 and mem_mask=0 in the same cycle.
REQ-018 On an accepted in-range store, SHALL drive mem_addr=rn_addr, mem_sdata=rn_wdata, mem_mask=rn_mask and mem_lenable=0 in the same cycle.
REQ-019 In idle cycles, SHALL drive mem_mask=0 and mem_lenable=0; mem_addr and mem_sdata are don't-care but SHALL hold their last value.
REQ-020 SHALL never let a store reach memory with mem_mask nonzero unless accepted and in range.
REQ-021 For an accepted in-range load, SHALL pulse rn_rvalid for exactly one cycle, one cycle after acceptance, to the issuing requester, with rn_rdata=mem_ldata.
REQ-022 SHALL use a 1-bit registered response tag to route load data, so back-to-back loads from alternating requesters each return to the correct requester.
REQ-023 Stores SHALL complete in the acceptance cycle and SHALL produce no rvalid.
REQ-024 For an accepted out-of-range access (load or store), SHALL drive mem_mask=0 and mem_lenable=0.
REQ-025 For such an out-of-range access, one cycle later SHALL pulse rn_err=1 and rn_rvalid=1 for one cycle with rn_rdata=0.
REQ-026 rn_rdata SHALL be 0 in every cycle where rn_rvalid=0.
REQ-027 SHALL allow a new access in the same cycle a prior load's response is returned, giving full throughput of one access per cycle.

Reset
REQ-028 While rst=1, SHALL hold all rn_gnt, rn_rvalid, rn_err, mem_lenable and mem_mask at 0, and all rn_rdata, mem_addr and mem_sdata at 0.
REQ-029 On reset, SHALL set the last-grant register to 1 (requester 0 wins the first contended cycle), clear the lock-held state and clear the pending response.
REQ-030 SHALL discard any response pending when rst is asserted; no rvalid SHALL appear in the cycle after reset deasserts.

Verification
REQ-031 r0 load at 0x10 only, with memory word 4 = 0xDEADBEEF: r0_gnt=1 same cycle, mem_lenable=1, and next cycle r0_rvalid=1 with r0_rdata=0xDEADBEEF.
REQ-032 Both requesting continuously with RR_EN=1 after reset: grants alternate r0,r1,r0,r1; with RR_EN=0, r0 is granted every cycle.
REQ-033 r1 store at 0x8 with mask 4'b0011 and data 0x12345678: mem_mask=4'b0011 and mem_sdata=0x12345678 for one cycle, then a load at 0x8 returns low half 0x5678 and upper bytes unchanged.
REQ-034 r0 load at address SIZE*4 (0x4000 for SIZE=4096): mem_lenable=0, and next cycle r0_err=1, r0_rvalid=1, r0_rdata=0.
REQ-035 r1_lock=1 with r1 granted and three further r1 requests while r0 requests: r1 is granted four consecutive cycles; r0 is granted in the cycle after r1_req drops.
REQ-036 Reset asserted in the cycle after an accepted load: no r0_rvalid appears afterwards, outputs are 0, and the first contended grant goes to r0.
